fifo_uart_tx_drain: RTL and testbench

//  Downstream consumer of the 8-deep byte FIFO. Pops one byte at a time via the FIFO read port
//  and serialises it onto a UART-style line: start bit, 8 data bits LSB-first, optional even

---
 rtl/fifo_uart_tx_drain.sv | 183 ++++++++++++++++++
 tb/tb_fifo_uart_tx_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_drain
// Pops bytes from a one-cycle-latency byte FIFO and serialises each one onto a
// UART-style line: start bit (0), DATA_W data bits LSB-first, an optional even
// parity bit, then a stop bit (1). Every serial bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_W        data byte width, matches the FIFO read data width
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//   PARITY_EN     1 inserts an even-parity bit between the data and stop bits
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous reset, active-low
//   en          in   allows new bytes to be popped; a running frame always ends
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after rd_en
//   rd_en       out  FIFO pop strobe, one-cycle pulse per byte (combinational)
//   tx          out  serial line, idle high (registered)
//   busy        out  high whenever the block is not idle
//   bytes_sent  out  count of completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fifo_uart_tx_drain #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd_en,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        bytes_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic [7:0]          sent_q, sent_d;
  logic                baud_last;

  assign rd_en      = (state_q == S_IDLE) && en && !fifo_empty;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign bytes_sent = sent_q;
  assign baud_last  = (baud_q == BAUD_LAST);

  // Next-state, counters and the value tx takes after the coming edge.
  // tx_d is loaded one cycle ahead so the line changes exactly at bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (rd_en) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // FIFO data is valid now; parity is taken here because the shift
        // register is consumed while the data bits go out.
        shift_d = fifo_dout;
        par_d   = even_parity(fifo_dout);
        baud_d  = BAUD_ZERO;
        bit_d   = BIT_ZERO;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = BAUD_ZERO;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = BAUD_ZERO;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d = BIT_ZERO;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1'b1);
            tx_d  = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = BAUD_ZERO;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = BAUD_ZERO;
          sent_d  = sent_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = BIT_ZERO;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= BAUD_ZERO;
      bit_q   <= BIT_ZERO;
      shift_q <= {DATA_W{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      sent_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      sent_q  <= sent_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: three independent lanes with different
// CLKS_PER_BIT / PARITY_EN settings, each with a queue-based FIFO model, a
// stimulus process, and a line monitor that decodes frames and compares them
// against a scoreboard of bytes pushed by the stimulus.
module tb_fifo_uart_tx_drain;

  logic clk = 1'b0;
  int   ncyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index, stable when sampled on the falling edge.
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", ln, nm, act, exp, ncyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int C  = (g == 2) ? 1 : 4;
    localparam int P  = (g == 0) ? 0 : 1;
    localparam int NB = 10 + P;

    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'd0;
    logic       rd_en, tx, busy;
    logic [7:0] bytes_sent;
    logic       done = 1'b0;

    logic [7:0] mem[$];
    logic [7:0] exp_q[$];
    int pop_cnt = 0;
    int pushed = 0;
    int last_pop = -100;
    int exp_sent = 0;
    int rst_edges = 0;

    fifo_uart_tx_drain #(
      .DATA_W(8), .CLKS_PER_BIT(C), .PARITY_EN(P)
    ) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .rd_en(rd_en), .tx(tx), .busy(busy), .bytes_sent(bytes_sent)
    );

    // Counts reset edges so the monitor can tell a frame was aborted.
    always @(posedge clk) if (!rst) rst_edges <= rst_edges + 1;

    task automatic push(input logic [7:0] b);
      mem.push_back(b);
      exp_q.push_back(b);
      pushed++;
    endtask

    // FIFO model: pop seen mid-cycle, data presented during the following cycle.
    initial begin : fifo_model
      logic pend;
      pend = 1'b0;
      forever begin
        @(negedge clk);
        if (rd_en === 1'b1) begin
          chk("pop_when_nonempty", g, (mem.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          pend = 1'b1;
          last_pop = ncyc;
          pop_cnt++;
        end
        @(posedge clk);
        #1;
        if (pend) begin
          if (mem.size() > 0) fifo_dout = mem.pop_front();
          pend = 1'b0;
        end
        fifo_empty = (mem.size() == 0);
      end
    end

    // Line monitor: finds start bits, samples every cycle of the frame.
    initial begin : monitor
      int s, seen;
      logic [10:0] bits, eb;
      logic [7:0] e;
      logic cur, glitch, bsy_bad, aborted;
      seen = 0;
      forever begin
        @(negedge clk);
        if (rst_edges != seen) begin
          seen = rst_edges;
          exp_sent = 0;
        end
        if (rst === 1'b1 && tx === 1'b0) begin
          s = ncyc;
          chk("start_latency", g, s, last_pop + 2);
          chk("frame_expected", g, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          e = (exp_q.size() > 0) ? exp_q[0] : 8'd0;
          bits = 11'd0; aborted = 1'b0; glitch = 1'b0; bsy_bad = 1'b0; cur = 1'b0;
          for (int b = 0; b < NB && !aborted; b++) begin
            for (int k = 0; k < C && !aborted; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (rst_edges != seen) begin
                aborted = 1'b1;
              end else begin
                if (k == 0) begin
                  cur = tx;
                  bits[b] = tx;
                end else if (tx !== cur) begin
                  glitch = 1'b1;
                end
                if (busy !== 1'b1) bsy_bad = 1'b1;
              end
            end
          end
          if (aborted) begin
            seen = rst_edges;
            exp_sent = 0;
          end else begin
            // Expected frame built straight from the byte: 0, data LSB first, parity, 1.
            eb = 11'd0;
            for (int i = 0; i < 8; i++) eb[1 + i] = e[i];
            if (P != 0) eb[9] = ^e;
            eb[NB - 1] = 1'b1;
            chk("frame_bits", g, {21'd0, bits}, {21'd0, eb});
            chk("bit_stable", g, {31'd0, glitch}, 32'd0);
            chk("busy_in_frame", g, {31'd0, bsy_bad}, 32'd0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_sent++;
            @(negedge clk);
            chk("bytes_sent", g, {24'd0, bytes_sent}, exp_sent % 256);
            chk("idle_after_stop", g, {30'd0, busy, tx}, 32'd1);
            if (en === 1'b1 && fifo_empty === 1'b0)
              chk("back_to_back_pop", g, {31'd0, rd_en}, 32'd1);
          end
        end
      end
    end

    task automatic wait_exp(input int n, input int budget);
      int t;
      t = 0;
      @(negedge clk);
      while (!(exp_q.size() == n && busy === 1'b0) && t < budget) begin
        @(negedge clk);
        t++;
      end
      chk("drain", g, exp_q.size(), n);
    endtask

    task automatic wait_start(input int budget);
      int t;
      t = 0;
      @(negedge clk);
      while (tx !== 1'b0 && t < budget) begin
        @(negedge clk);
        t++;
      end
      chk("start_seen", g, {31'd0, tx}, 32'd0);
    endtask

    initial begin : stim
      // Held in reset with a byte waiting and en low; then 20 quiet cycles.
      push(8'hA5);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) begin
        @(negedge clk);
        chk("reset_idle", g, {21'd0, tx, rd_en, busy, bytes_sent}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      end

      // Reset during data bit 3: the in-flight byte is lost, the next one is sent.
      push(8'h5A);
      @(posedge clk);
      #1 en = 1'b1;
      wait_start(50);
      repeat (4 * C) @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);
      chk("reset_abort", g, {22'd0, tx, busy, bytes_sent}, {22'd0, 1'b1, 1'b0, 8'd0});
      void'(exp_q.pop_front());
      @(posedge clk);
      #1 rst = 1'b1;
      en = 1'b1;
      wait_exp(0, 400);

      // Single byte, a burst of three, then the two parity patterns.
      push(8'hA5);
      wait_exp(0, 400);
      push(8'h00); push(8'hFF); push(8'h3C);
      wait_exp(0, 800);
      push(8'h07); push(8'h03);
      wait_exp(0, 600);

      // en dropped during START: current frame finishes, nothing more is popped.
      for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
      wait_start(50);
      en = 1'b0;
      wait_exp(2, 400);
      repeat (20) @(negedge clk);
      chk("no_pop_after_en_drop", g, mem.size(), 2);
      chk("idle_after_en_drop", g, {30'd0, busy, tx}, 32'd1);

      // Random bytes until 256 frames have completed since reset.
      @(posedge clk);
      #1 en = 1'b1;
      for (int i = 0; i < 246; i++) push(8'($urandom_range(0, 255)));
      wait_exp(0, 20000);
      chk("bytes_sent_wrap", g, {24'd0, bytes_sent}, 32'd0);
      chk("pop_count", g, pop_cnt, pushed);
      done = 1'b1;
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    chk("all_lanes_done", 9,
        {29'd0, lane[2].done, lane[1].done, lane[0].done}, 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
